trap_halt_ctrl: RTL and testbench

- Consumes the two-cycle-delayed ebreak pulse from the ebreak delay stage.
- Turns it into a simulation stop: requests a pipeline freeze, drains for a fixed window, then asserts a sticky halt.
- Captures exit code (a0), trap PC, and cycle/instruction counts for the testbench and difftest.
- Sits between the ebreak delay stage and the top-level sim-control outputs.

---
 rtl/trap_halt_ctrl.sv | 168 ++++++++++++++++
 tb/tb_trap_halt_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_halt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_halt_ctrl
// Purpose  : Turns the delayed ebreak pulse into freeze -> drain -> sticky halt
//            and captures exit code, trap PC and run counters.
//            Optional no-commit watchdog enabled by macro TRAP_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module trap_halt_ctrl #(
  parameter int XLEN           = 64,
  parameter int CNT_W          = 64,
  parameter int DRAIN_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ebreak,
  input  logic             i_commit_valid,
  input  logic [XLEN-1:0]  i_commit_pc,
  input  logic [XLEN-1:0]  i_a0_data,
  output logic             o_halt_req,
  output logic             o_halt_done,
  output logic             o_good_trap,
  output logic [XLEN-1:0]  o_trap_pc,
  output logic [XLEN-1:0]  o_trap_code,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instr_cnt,
  output logic             o_timeout_flag
);

  localparam int            DW           = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] C_DRAIN_LOAD = DW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DW-1:0]     r_drain;
  logic [XLEN-1:0]   r_last_pc;
  logic              r_halt_req;
  logic              r_halt_done;
  logic              r_good_trap;
  logic [XLEN-1:0]   r_trap_pc;
  logic [XLEN-1:0]   r_trap_code;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_instr_cnt;
  logic              w_timeout;
  logic              w_capture;
  logic [XLEN-1:0]   w_code_cap;
  logic [XLEN-1:0]   w_pc_cap;

`ifdef TRAP_TIMEOUT_EN
  localparam int IW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] C_TIMEOUT = IW'(TIMEOUT_CYCLES);

  logic [IW-1:0] r_idle;
  logic          r_timeout_flag;

  // A commit in the firing cycle counts as activity; ebreak always has priority.
  assign w_timeout = (r_state == ST_RUN) && !i_ebreak && !i_commit_valid && (r_idle == C_TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle         <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (r_state == ST_RUN) begin
        if (i_commit_valid) begin
          r_idle <= '0;
        end else if (r_idle != C_TIMEOUT) begin
          r_idle <= r_idle + IW'(1);
        end
      end
      if (w_timeout) begin
        r_timeout_flag <= 1'b1;
      end
    end
  end

  assign o_timeout_flag = r_timeout_flag;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
  assign o_timeout_flag   = 1'b0;
`endif

  assign w_capture  = (r_state == ST_RUN) && (i_ebreak || w_timeout);
  assign w_code_cap = w_timeout ? {XLEN{1'b1}} : i_a0_data;
  assign w_pc_cap   = i_commit_valid ? i_commit_pc : r_last_pc;

  // DRAIN occupies exactly DRAIN_CYCLES cycles, so leave when the count hits 1.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_capture) begin
          w_state_nxt = (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_drain <= DW'(1)) begin
          w_state_nxt = ST_HALTED;
        end
      end
      default: w_state_nxt = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain     <= '0;
      r_last_pc   <= '0;
      r_halt_req  <= 1'b0;
      r_halt_done <= 1'b0;
      r_good_trap <= 1'b0;
      r_trap_pc   <= '0;
      r_trap_code <= '0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_halt_req  <= (w_state_nxt != ST_RUN);
      r_halt_done <= (w_state_nxt == ST_HALTED);

      if (r_state == ST_RUN) begin
        if (!(&r_cycle_cnt)) begin
          r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
        if (i_commit_valid) begin
          if (!(&r_instr_cnt)) begin
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
          end
          r_last_pc <= i_commit_pc;
        end
      end

      if (w_capture) begin
        r_trap_code <= w_code_cap;
        r_trap_pc   <= w_pc_cap;
        r_drain     <= C_DRAIN_LOAD;
      end else if (r_state == ST_DRAIN) begin
        r_drain <= r_drain - DW'(1);
      end

      // With no drain window the code is captured on the same edge as the halt.
      if ((w_state_nxt == ST_HALTED) && (r_state != ST_HALTED)) begin
        r_good_trap <= w_capture ? (w_code_cap == '0) : (r_trap_code == '0);
      end
    end
  end

  assign o_halt_req  = r_halt_req;
  assign o_halt_done = r_halt_done;
  assign o_good_trap = r_good_trap;
  assign o_trap_pc   = r_trap_pc;
  assign o_trap_code = r_trap_code;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_instr_cnt = r_instr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trap_halt_ctrl.sv
`default_nettype none
// Testbench for trap_halt_ctrl: randomized commits/ebreaks against a reference
// model; a second instance covers the zero-length drain window.
module tb_trap_halt_ctrl;

  localparam int DRAIN = 2;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ebreak = 1'b0;
  logic        cv = 1'b0;
  logic [63:0] cpc = '0;
  logic [63:0] a0 = '0;

  logic        req, done, good, tflag;
  logic [63:0] tpc, tcode, cyc, ins;
  logic        z_req, z_done, z_good, z_tflag;
  logic [63:0] z_tpc, z_tcode, z_cyc, z_ins;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit              m_run = 1'b1;
  int              m_since = 0;
  longint unsigned m_cyc = 0;
  longint unsigned m_ins = 0;
  logic [63:0]     m_last = '0;
  logic [63:0]     m_code = '0;
  logic [63:0]     m_pc = '0;
  int              m_idle = 0;
  bit              m_tmo = 1'b0;

  trap_halt_ctrl #(.XLEN(64), .CNT_W(64), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .i_ebreak(ebreak), .i_commit_valid(cv), .i_commit_pc(cpc),
    .i_a0_data(a0), .o_halt_req(req), .o_halt_done(done), .o_good_trap(good),
    .o_trap_pc(tpc), .o_trap_code(tcode), .o_cycle_cnt(cyc), .o_instr_cnt(ins),
    .o_timeout_flag(tflag)
  );

  trap_halt_ctrl #(.XLEN(64), .CNT_W(64), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .rst(rst), .i_ebreak(ebreak), .i_commit_valid(cv), .i_commit_pc(cpc),
    .i_a0_data(a0), .o_halt_req(z_req), .o_halt_done(z_done), .o_good_trap(z_good),
    .o_trap_pc(z_tpc), .o_trap_code(z_tcode), .o_cycle_cnt(z_cyc), .o_instr_cnt(z_ins),
    .o_timeout_flag(z_tflag)
  );

  always #5 clk = ~clk;

  function automatic bit e_req();
    return !m_run;
  endfunction

  function automatic bit e_done();
    return !m_run && (m_since >= DRAIN);
  endfunction

  function automatic bit e_good();
    return e_done() && (m_code == 64'd0);
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input bit r, input bit e, input bit c, input logic [63:0] pc, input logic [63:0] a);
    bit tmo;
    tmo = 1'b0;
    rst = r; ebreak = e; cv = c; cpc = pc; a0 = a;
    @(posedge clk);
    if (r) begin
      m_run = 1'b1; m_since = 0; m_cyc = 0; m_ins = 0;
      m_last = '0; m_code = '0; m_pc = '0; m_idle = 0; m_tmo = 1'b0;
    end else if (m_run) begin
`ifdef TRAP_TIMEOUT_EN
      tmo = !e && !c && (m_idle >= TMO);
      m_idle = c ? 0 : m_idle + 1;
`endif
      m_cyc++;
      if (e || tmo) begin
        m_run = 1'b0; m_since = 0; m_tmo = tmo;
        m_code = tmo ? '1 : a;
        m_pc = c ? pc : m_last;
      end
      if (c) begin
        m_ins++;
        m_last = pc;
      end
    end else begin
      m_since++;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 64'h1234, 64'h55);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if ({req, done, good, tflag} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_flags got %b required 0000", {req, done, good, tflag});
    end
    n_checks++;
    if (tpc !== 64'd0 || tcode !== 64'd0) begin
      n_errors++; $display("FAIL reset_capture got pc=%h code=%h required 0", tpc, tcode);
    end
    n_checks++;
    if (cyc !== 64'd0 || ins !== 64'd0) begin
      n_errors++; $display("FAIL reset_counters got cyc=%0d ins=%0d required 0", cyc, ins);
    end
    n_checks++;
    if ({z_req, z_done, z_good, z_tflag} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_dut0 got %b required 0000", {z_req, z_done, z_good, z_tflag});
    end
  endtask

  task automatic test_good_trap();
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1, 64'h8000_0000 + 64'(4 * k), 64'($urandom));
    step(1'b0, 1'b1, 1'b0, 64'hdead_beef, 64'd0);
    n_checks++;
    if ({req, done} !== 2'b10) begin
      n_errors++; $display("FAIL good_T+1 got req/done=%b required 10", {req, done});
    end
    step(1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if ({req, done} !== 2'b10) begin
      n_errors++; $display("FAIL good_T+2 got req/done=%b required 10", {req, done});
    end
    step(1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if ({req, done, good} !== 3'b111) begin
      n_errors++; $display("FAIL good_T+3 got req/done/good=%b required 111", {req, done, good});
    end
    n_checks++;
    if (tpc !== 64'h8000_0024 || tcode !== 64'd0 || ins !== 64'd10 || cyc !== 64'd11) begin
      n_errors++;
      $display("FAIL good_capture got pc=%h code=%h ins=%0d cyc=%0d required 80000024/0/10/11", tpc, tcode, ins, cyc);
    end
  endtask

  task automatic test_bad_trap();
    int n_commit;
    int idle;
    bit c;
    n_commit = 0;
    idle = 0;
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < int'($urandom_range(3, 12)); i++) begin
      c = ($urandom_range(0, 1) == 1) || (idle >= 5);
      idle = c ? 0 : idle + 1;
      if (c) n_commit++;
      step(1'b0, 1'b0, c, {32'd0, $urandom}, 64'($urandom));
    end
    step(1'b0, 1'b1, 1'b1, 64'h8000_0100, 64'd1);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if ({req, done, good} !== 3'b110) begin
      n_errors++; $display("FAIL bad_flags got req/done/good=%b required 110", {req, done, good});
    end
    n_checks++;
    if (tpc !== 64'h8000_0100 || tcode !== 64'd1) begin
      n_errors++; $display("FAIL bad_capture got pc=%h code=%h required 80000100/1", tpc, tcode);
    end
    n_checks++;
    if (ins !== 64'(n_commit + 1)) begin
      n_errors++; $display("FAIL bad_instr got %0d required %0d", ins, n_commit + 1);
    end
  endtask

  task automatic test_ignore();
    bit seen_done;
    seen_done = 1'b0;
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 64'h100 + 64'(4 * k), '0);
    step(1'b0, 1'b1, 1'b0, '0, 64'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, {32'd0, $urandom}, 64'd5);
      n_checks++;
      if (cyc !== 64'd5 || ins !== 64'd4 || tcode !== 64'd0 || (seen_done && !done)) begin
        n_errors++;
        $display("FAIL ignore[%0d] got cyc=%0d ins=%0d code=%h done=%b required 5/4/0 done sticky", i, cyc, ins, tcode, done);
      end
      seen_done = seen_done | done;
    end
    n_checks++;
    if ({done, good} !== 2'b11) begin
      n_errors++; $display("FAIL ignore_end got done/good=%b required 11", {done, good});
    end
  endtask

  task automatic test_reset_mid_drain();
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 64'h200 + 64'(4 * k), '0);
    step(1'b0, 1'b1, 1'b0, '0, 64'd7);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if ({req, done, good, tflag} !== 4'b0000 || tpc !== 64'd0 || tcode !== 64'd0 || cyc !== 64'd0 || ins !== 64'd0) begin
      n_errors++;
      $display("FAIL midrst got flags=%b pc=%h code=%h cyc=%0d ins=%0d required all 0", {req, done, good, tflag}, tpc, tcode, cyc, ins);
    end
    step(1'b0, 1'b0, 1'b1, 64'h300, '0);
    step(1'b0, 1'b0, 1'b1, 64'h304, '0);
    step(1'b0, 1'b1, 1'b0, '0, 64'd0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if ({done, good} !== 2'b11 || ins !== 64'd2 || tpc !== 64'h304) begin
      n_errors++; $display("FAIL midrst_rehalt got done/good=%b ins=%0d pc=%h required 11/2/304", {done, good}, ins, tpc);
    end
  endtask

  task automatic test_drain_zero();
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 64'h400, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    n_checks++;
    if ({z_req, z_done} !== 2'b00) begin
      n_errors++; $display("FAIL dz_before got req/done=%b required 00", {z_req, z_done});
    end
    step(1'b0, 1'b1, 1'b0, '0, 64'd3);
    n_checks++;
    if ({z_req, z_done, z_good} !== 3'b110 || z_tcode !== 64'd3 || z_tpc !== 64'h400) begin
      n_errors++;
      $display("FAIL dz_T+1 got req/done/good=%b code=%h pc=%h required 110/3/400", {z_req, z_done, z_good}, z_tcode, z_tpc);
    end
    n_checks++;
    if ({req, done} !== 2'b10) begin
      n_errors++; $display("FAIL dz_contrast got req/done=%b required 10", {req, done});
    end
  endtask

  task automatic test_random();
    int idle;
    int len;
    bit c;
    bit e;
    for (int it = 0; it < 8; it++) begin
      idle = 0;
      len = int'($urandom_range(2, 20));
      step(1'b1, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < len + 5; i++) begin
        c = ($urandom_range(0, 2) != 0) || (idle >= 5);
        idle = c ? 0 : idle + 1;
        e = ($urandom_range(0, 7) == 0) || (i == len - 1);
        step(1'b0, e, c, {32'h8000_0000, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC,
             ($urandom_range(0, 1) == 1) ? 64'd0 : {$urandom, $urandom});
        n_checks++;
        if ({req, done, good, tflag} !== {e_req(), e_done(), e_good(), m_tmo} || cyc !== m_cyc ||
            ins !== m_ins || tpc !== m_pc || tcode !== m_code) begin
          n_errors++;
          $display("FAIL random[%0d.%0d] got flags=%b cyc=%0d ins=%0d pc=%h code=%h required flags=%b cyc=%0d ins=%0d pc=%h code=%h",
                   it, i, {req, done, good, tflag}, cyc, ins, tpc, tcode,
                   {e_req(), e_done(), e_good(), m_tmo}, m_cyc, m_ins, m_pc, m_code);
        end
      end
    end
  endtask

`ifdef TRAP_TIMEOUT_EN
  task automatic test_timeout();
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, 64'h8000_0040, '0);
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0);
      n_checks++;
      if (req !== (i >= TMO) || req !== e_req()) begin
        n_errors++; $display("FAIL timeout_req[%0d] got %b required %b", i, req, (i >= TMO));
      end
    end
    n_checks++;
    if ({done, good, tflag} !== 3'b101 || tcode !== 64'hFFFF_FFFF_FFFF_FFFF || tpc !== 64'h8000_0040) begin
      n_errors++;
      $display("FAIL timeout_halt got done/good/tmo=%b code=%h pc=%h required 101/all-ones/80000040", {done, good, tflag}, tcode, tpc);
    end
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int r = 0; r < 5; r++) begin
      step(1'b0, 1'b0, 1'b1, 64'h500 + 64'(4 * r), '0);
      for (int i = 0; i < TMO - 1; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
      n_checks++;
      if ({req, tflag} !== 2'b00) begin
        n_errors++; $display("FAIL watchdog_kick[%0d] got req/tmo=%b required 00", r, {req, tflag});
      end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_good_trap();
    test_bad_trap();
    test_ignore();
    test_reset_mid_drain();
    test_drain_zero();
    test_random();
`ifdef TRAP_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
